up3_run_ctl: RTL and testbench

//  Execution sequencer for the up3 CPU datapath on the DE-series board. Replaces the raw

---
 rtl/up3_run_ctl.sv | 181 ++++++++++++++++++
 tb/tb_up3_run_ctl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/up3_run_ctl.sv
// ============================================================================
// Module   : up3_run_ctl
// Brief    : Execution sequencer for the up3 CPU. Turns the step and run/stop
//            buttons into a one-cycle cpu_en clock-enable. It supports:
//              - single-state step
//              - single-instruction step
//              - divided-rate free run
//              - halt on a PC breakpoint or on the HALT opcode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module up3_run_ctl #(
  parameter int unsigned TICK_DIV = 25_000_000, // clk cycles per cpu_en in RUN (>=2)
  parameter logic [7:0]  HALT_OP  = 8'hFF,      // opcode that stops RUN
  parameter int unsigned CNT_W    = 16          // width of cycle_cnt
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_req,
  input  logic             run_req,
  input  logic             step_instr,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       pc,
  input  logic [7:0]       opcode,
  input  logic             fetch,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [1:0]       ctl_state,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned       TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_STEP = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  logic              step_meta_q, step_sync_q, step_prev_q;
  logic              run_meta_q,  run_sync_q,  run_prev_q;
  logic [1:0]        state_q,      state_d;
  logic [TICK_W-1:0] tick_q,       tick_d;
  logic              bp_skip_q,    bp_skip_d;
  logic              step_first_q, step_first_d;
  logic [CNT_W-1:0]  cycle_cnt_q;

  logic step_rise;
  logic run_rise;
  logic bp_hit;
  logic en_now;

  // Two-flop synchronizers plus a previous-value flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
      run_meta_q  <= 1'b0;
      run_sync_q  <= 1'b0;
      run_prev_q  <= 1'b0;
    end else begin
      step_meta_q <= step_req;
      step_sync_q <= step_meta_q;
      step_prev_q <= step_sync_q;
      run_meta_q  <= run_req;
      run_sync_q  <= run_meta_q;
      run_prev_q  <= run_sync_q;
    end
  end

  assign step_rise = step_sync_q & ~step_prev_q;
  assign run_rise  = run_sync_q  & ~run_prev_q;

  // bp_skip masks the stop condition once, so the CPU can execute past
  // the instruction it halted on.
  assign bp_hit = fetch & ~bp_skip_q &
                  ((bp_en & (pc == bp_addr)) | (opcode == HALT_OP));

  // Next-state logic. cpu_en is decoded combinationally from the current
  // state, so an asynchronous reset removes an in-flight pulse at once.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bp_skip_d    = bp_skip_q;
    step_first_d = 1'b0;
    en_now       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          state_d = S_RUN;
          tick_d  = '0;
        end else if (step_rise) begin
          state_d      = S_STEP;
          step_first_d = 1'b1;
        end
      end
      S_STEP: begin
        // Entry cycle always pulses; instruction step keeps pulsing until
        // the CPU is back at fetch.
        if (step_first_q) begin
          en_now = 1'b1;
        end else if (step_instr && !fetch) begin
          en_now = 1'b1;
        end
        if (run_rise) begin
          state_d = S_RUN;
          tick_d  = '0;
        end else if (!step_instr || !en_now) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (run_rise) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else begin
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            if (bp_hit) begin
              state_d = S_HALT;
            end else begin
              en_now = 1'b1;
              if (fetch) begin
                bp_skip_d = 1'b0;
              end
            end
          end
        end
      end
      S_HALT: begin
        if (run_rise) begin
          state_d   = S_RUN;
          tick_d    = '0;
          bp_skip_d = 1'b1;
        end else if (step_rise) begin
          state_d      = S_STEP;
          step_first_d = 1'b1;
          bp_skip_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, tick divider and breakpoint-skip registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bp_skip_q    <= 1'b0;
      step_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bp_skip_q    <= bp_skip_d;
      step_first_q <= step_first_d;
    end
  end

  // Saturating count of issued cpu_en pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
    end else if (en_now && (cycle_cnt_q != '1)) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  assign cpu_en    = en_now;
  assign running   = (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);
  assign ctl_state = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_up3_run_ctl.sv
// ============================================================================
// Module   : tb_up3_run_ctl
// Brief    : Self-checking bench for up3_run_ctl (TICK_DIV=4, CNT_W=4).
//            Expected cpu_en cycle numbers are queued when stimulus is
//            applied and popped as pulses appear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_up3_run_ctl;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             step_req = 1'b0;
  logic             run_req = 1'b0;
  logic             step_instr = 1'b0;
  logic             bp_en = 1'b0;
  logic [7:0]       bp_addr = 8'h00;
  logic [7:0]       pc;
  logic [7:0]       opcode = 8'h00;
  logic             fetch = 1'b1;
  logic             cpu_en;
  logic             running;
  logic             halted;
  logic [1:0]       ctl_state;
  logic [CNT_W-1:0] cycle_cnt;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int base;

  up3_run_ctl #(
    .TICK_DIV (TICK_DIV),
    .HALT_OP  (8'hFF),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step_req   (step_req),
    .run_req    (run_req),
    .step_instr (step_instr),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .opcode     (opcode),
    .fetch      (fetch),
    .cpu_en     (cpu_en),
    .running    (running),
    .halted     (halted),
    .ctl_state  (ctl_state),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Count rising edges; value N means N edges have occurred.
  always @(posedge clk) cyc <= cyc + 1;

  // Minimal CPU model: PC advances on each enabled cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= 8'h00;
    else if (cpu_en) pc <= pc + 8'h01;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every observed pulse must match the next queued cycle.
  always @(negedge clk) begin
    if (cpu_en === 1'b1) begin
      int e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      check("pulse_cyc", cyc, e);
    end
  end

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step_clk(2);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    step_clk(2);
    check("rst_cpu_en",  cpu_en,    0);
    check("rst_state",   ctl_state, 2'b00);
    check("rst_running", running,   0);
    check("rst_halted",  halted,    0);
    check("rst_cnt",     cycle_cnt, 0);
    reset = 1'b0;

    // Single-state step with the button held for 10 cycles
    step_instr = 1'b0;
    base = cyc;
    step_req = 1'b1;
    exp_q.push_back(base + 3);
    step_clk(10);
    step_req = 1'b0;
    step_clk(4);
    check("sstep_cnt",   cycle_cnt,     1);
    check("sstep_state", ctl_state,     2'b00);
    check("sstep_q",     exp_q.size(),  0);

    // Instruction step: entry pulse plus three fetch-low cycles
    do_reset();
    step_instr = 1'b1;
    fetch = 1'b0;
    base = cyc;
    step_req = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(base + 3 + k);
    step_clk(1);
    step_req = 1'b0;
    step_clk(6);
    fetch = 1'b1;
    step_clk(3);
    check("istep_cnt",   cycle_cnt,    4);
    check("istep_state", ctl_state,    2'b00);
    check("istep_q",     exp_q.size(), 0);

    // Reset arriving during a RUN pulse
    do_reset();
    step_instr = 1'b0;
    fetch = 1'b1;
    base = cyc;
    run_req = 1'b1;
    step_clk(1);
    run_req = 1'b0;
    step_clk(5);
    check("mid_run_pulse", cpu_en, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_cpu_en", cpu_en,    0);
    check("mid_rst_state",  ctl_state, 2'b00);
    check("mid_rst_cnt",    cycle_cnt, 0);
    step_clk(1);
    reset = 1'b0;

    // RUN until PC breakpoint at 8'h05
    bp_en = 1'b1;
    bp_addr = 8'h05;
    opcode = 8'h00;
    base = cyc;
    run_req = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(base + 6 + 4 * k);
    step_clk(1);
    run_req = 1'b0;
    step_clk(28);
    check("bp_state",   ctl_state,    2'b11);
    check("bp_halted",  halted,       1);
    check("bp_running", running,      0);
    check("bp_cnt",     cycle_cnt,    5);
    check("bp_q",       exp_q.size(), 0);

    // Resume from the breakpoint, then stop on HALT_OP
    base = cyc;
    run_req = 1'b1;
    exp_q.push_back(base + 6);
    exp_q.push_back(base + 10);
    step_clk(1);
    run_req = 1'b0;
    step_clk(3);
    check("resume_state",   ctl_state, 2'b10);
    check("resume_running", running,   1);
    step_clk(8);
    opcode = 8'hFF;
    step_clk(6);
    check("hop_state",  ctl_state,    2'b11);
    check("hop_halted", halted,       1);
    check("hop_cnt",    cycle_cnt,    7);
    check("hop_q",      exp_q.size(), 0);

    // Simultaneous step and run from IDLE; run counter to saturation
    do_reset();
    opcode = 8'h00;
    bp_en = 1'b0;
    fetch = 1'b1;
    base = cyc;
    step_req = 1'b1;
    run_req = 1'b1;
    for (int k = 0; k < 18; k++) exp_q.push_back(base + 6 + 4 * k);
    step_clk(1);
    step_req = 1'b0;
    run_req = 1'b0;
    step_clk(4);
    check("both_state",   ctl_state, 2'b10);
    check("both_running", running,   1);
    step_clk(72);
    check("sat_cnt", cycle_cnt,    4'hF);
    check("sat_q",   exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
